// File: rtl/collatz_sched.sv
// Round-robin scheduler that shares one collatz iterator between NREQ requesters.
// Optional iteration limit enabled by defining COLLATZ_SCHED_TIMEOUT_EN.
module collatz_sched #(
  parameter int NREQ       = 4,
  parameter int ID_BITS    = 2,
  parameter int COUNT_BITS = 16,
  parameter int MAX_ITER   = 1000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*32-1:0]      req_n,
  output logic [NREQ-1:0]         gnt,
  output logic                    cgo,
  output logic [31:0]             cn,
  input  logic                    cdone,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_BITS-1:0]      rsp_id,
  output logic [COUNT_BITS-1:0]   rsp_count,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int PW = ID_BITS + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_BITS-1:0]      ptr_q, ptr_d;
  logic [ID_BITS-1:0]      id_q, id_d;
  logic [31:0]             cn_q, cn_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic [ID_BITS-1:0]      rsp_id_q, rsp_id_d;
  logic [COUNT_BITS-1:0]   rsp_count_q, rsp_count_d;
  logic                    rsp_err_q, rsp_err_d;

  logic [31:0]             req_val [NREQ];
  logic [NREQ-1:0]         req_rot;
  logic                    sel_found;
  logic [PW-1:0]           sel_off;
  logic [PW-1:0]           sel_sum;
  logic [ID_BITS-1:0]      sel_idx;
  logic [ID_BITS-1:0]      sel_next;
  logic [NREQ-1:0]         gnt_oh;

`ifdef COLLATZ_SCHED_TIMEOUT_EN
  localparam logic [COUNT_BITS-1:0] LIMIT_M1 = COUNT_BITS'(MAX_ITER - 1);
  localparam logic [COUNT_BITS-1:0] LIMIT    = COUNT_BITS'(MAX_ITER);
`else
  logic unused_max_iter;
  assign unused_max_iter = (MAX_ITER != 0);
`endif

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_val[gi] = req_n[32*gi +: 32];
    end
  endgenerate

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  always_comb begin
    req_rot   = NREQ'({req, req} >> ptr_q);
    sel_found = 1'b0;
    sel_off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        sel_found = 1'b1;
        sel_off   = PW'(k);
      end
    end
    sel_sum = PW'(ptr_q) + sel_off;
    if (sel_sum >= PW'(NREQ)) begin
      sel_idx = ID_BITS'(sel_sum - PW'(NREQ));
    end else begin
      sel_idx = ID_BITS'(sel_sum);
    end
    if (sel_idx == ID_BITS'(NREQ - 1)) begin
      sel_next = '0;
    end else begin
      sel_next = sel_idx + 1'b1;
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (state_q == S_IDLE && sel_found) begin
      gnt_oh[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cn_d        = cn_q;
    count_d     = count_q;
    rsp_id_d    = rsp_id_q;
    rsp_count_d = rsp_count_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          id_d    = sel_idx;
          cn_d    = req_val[sel_idx];
          ptr_d   = sel_next;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        count_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cdone) begin
          rsp_id_d    = id_q;
          rsp_count_d = count_q;
          rsp_err_d   = 1'b0;
          state_d     = S_RESP;
        end
`ifdef COLLATZ_SCHED_TIMEOUT_EN
        else if (count_q == LIMIT_M1) begin
          rsp_id_d    = id_q;
          rsp_count_d = LIMIT;
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end
`endif
        else if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      cn_q        <= '0;
      count_q     <= '0;
      rsp_id_q    <= '0;
      rsp_count_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cn_q        <= cn_d;
      count_q     <= count_d;
      rsp_id_q    <= rsp_id_d;
      rsp_count_q <= rsp_count_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Grant is combinational from IDLE, so mask it while reset is asserted.
  assign gnt       = gnt_oh & {NREQ{reset_n}};
  assign cgo       = (state_q == S_LAUNCH);
  assign cn        = cn_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_count = rsp_count_q;
`ifdef COLLATZ_SCHED_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign busy      = (state_q != S_IDLE);

`ifndef COLLATZ_SCHED_TIMEOUT_EN
  logic unused_err;
  assign unused_err = rsp_err_q;
`endif

endmodule

// File: tb/tb_collatz_sched.sv
// Scoreboard bench for collatz_sched with a behavioural collatz iterator.
// Timeout case runs only when COLLATZ_SCHED_TIMEOUT_EN is defined.
module tb_collatz_sched;
  localparam int NREQ       = 4;
  localparam int ID_BITS    = 2;
  localparam int COUNT_BITS = 16;
  localparam int MAX_ITER   = 1000;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*32-1:0]    req_n = '0;
  logic [NREQ-1:0]       gnt;
  logic                  cgo;
  logic [31:0]           cn;
  logic                  cdone;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_BITS-1:0]    rsp_id;
  logic [COUNT_BITS-1:0] rsp_count;
  logic                  rsp_err;
  logic                  busy;

  typedef struct packed {
    logic                  err;
    logic [ID_BITS-1:0]    id;
    logic [COUNT_BITS-1:0] count;
  } rsp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          exp_gnt[$];
  logic [31:0] exp_cn[$];
  rsp_t        exp_rsp[$];
  logic [31:0] it_v = 32'd0;

  collatz_sched #(
    .NREQ(NREQ), .ID_BITS(ID_BITS), .COUNT_BITS(COUNT_BITS), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_n(req_n), .gnt(gnt),
    .cgo(cgo), .cn(cn), .cdone(cdone), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_count(rsp_count),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Iterator model: loads on cgo, one collatz step per cycle, done at 1.
  always @(posedge clk) begin
    if (cgo) it_v <= cn;
    else if (it_v != 32'd1) it_v <= it_v[0] ? (it_v * 32'd3 + 32'd1) : (it_v >> 1);
  end
  assign cdone = (it_v == 32'd1);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents gnt, cgo or a response.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (reset_n) begin
      if (gnt != '0) begin
        if (exp_gnt.size() == 0) check("unexpected_gnt", 64'(gnt), 64'd0);
        else check("gnt", 64'(gnt), 64'(1 << exp_gnt.pop_front()));
      end
      if (cgo) begin
        if (exp_cn.size() == 0) check("unexpected_cgo", 64'(cgo), 64'd0);
        else check("cn", 64'(cn), 64'(exp_cn.pop_front()));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = exp_rsp.pop_front();
          $display("[TB] rsp id=%0d count=%0d err=%0d (exp id=%0d count=%0d err=%0d)",
                   rsp_id, rsp_count, rsp_err, e.id, e.count, e.err);
          check("rsp_id", 64'(rsp_id), 64'(e.id));
          check("rsp_count", 64'(rsp_count), 64'(e.count));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
  end

  task automatic expect_rsp(input int id, input int count, input logic err);
    rsp_t e;
    e.err   = err;
    e.id    = ID_BITS'(id);
    e.count = COUNT_BITS'(count);
    exp_rsp.push_back(e);
  endtask

  task automatic start_req(input int id, input logic [31:0] n);
    req_n[32*id +: 32] = n;
    req[id] = 1'b1;
    exp_gnt.push_back(id);
    exp_cn.push_back(n);
  endtask

  task automatic wait_gnt(input int id, input int bound, output int at_cyc);
    bit got = 1'b0;
    at_cyc = -1;
    for (int c = 0; c < bound && !got; c++) begin
      @(negedge clk);
      if (gnt[id]) begin
        got = 1'b1;
        at_cyc = cyc;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL gnt_wait: no gnt[%0d] within %0d cycles, required a grant", id, bound);
    end
  endtask

  task automatic issue(input int id, input logic [31:0] n);
    int t;
    start_req(id, n);
    wait_gnt(id, 50, t);
    @(posedge clk); #1;
    req[id] = 1'b0;
  endtask

  task automatic drain(input int bound);
    bit done = 1'b0;
    for (int c = 0; c < bound && !done; c++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses outstanding after %0d cycles, required 0",
               exp_rsp.size(), bound);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 64'(gnt), 64'd0);
    check({tag, "_cgo"}, 64'(cgo), 64'd0);
    check({tag, "_cn"}, 64'(cn), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    check({tag, "_rsp_count"}, 64'(rsp_count), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tg;
    int tr;
    bit seen;
    int order [5];

    // Reset state, with a request already pending
    req_n[31:0] = 32'd5;
    req[0] = 1'b1;
    #1;
    check_all_zero("reset");
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // n=6 on requester 0
    $display("[TB] txn: req0 n=6");
    expect_rsp(0, 8, 1'b0);
    issue(0, 32'd6);
    drain(100);

    // n=1 on requester 3: count 0, rsp_valid three cycles after gnt
    $display("[TB] txn: req3 n=1 latency");
    expect_rsp(3, 0, 1'b0);
    start_req(3, 32'd1);
    wait_gnt(3, 50, tg);
    @(posedge clk); #1;
    req[3] = 1'b0;
    tr = -1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        tr = cyc;
      end
    end
    check("latency_n1", 64'(tr - tg), 64'd3);
    drain(50);

    // All four requesters hold n=27; grants rotate 0,1,2,3,0
    $display("[TB] txn: round robin n=27 x5");
    order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) req_n[32*i +: 32] = 32'd27;
    for (int k = 0; k < 5; k++) begin
      exp_gnt.push_back(order[k]);
      exp_cn.push_back(32'd27);
      expect_rsp(order[k], 111, 1'b0);
    end
    req = '1;
    for (int k = 0; k < 5; k++) wait_gnt(order[k], 300, tg);
    @(posedge clk); #1;
    req = '0;
    drain(300);

    // Back-pressure: response held 10 cycles, pending request 2 not granted
    $display("[TB] txn: req1 n=6 with rsp_ready low");
    rsp_ready = 1'b0;
    expect_rsp(1, 8, 1'b0);
    issue(1, 32'd6);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("hold_rsp_seen", 64'(rsp_valid), 64'd1);
    @(posedge clk); #1;
    expect_rsp(2, 0, 1'b0);
    start_req(2, 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_id", 64'(rsp_id), 64'd1);
      check("hold_count", 64'(rsp_count), 64'd8);
      check("hold_err", 64'(rsp_err), 64'd0);
      check("hold_no_gnt", 64'(gnt), 64'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_gnt(2, 20, tg);
    @(posedge clk); #1;
    req[2] = 1'b0;
    drain(50);

    // Reset in the middle of a run: outputs clear at once, job is dropped
    $display("[TB] txn: req0 n=27 reset mid-run");
    issue(0, 32'd27);
    repeat (20) @(posedge clk);
    #1;
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_reset_busy", 64'(busy), 64'd0);
      check("post_reset_valid", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk); #1;
    $display("[TB] txn: req2 n=6 after reset");
    expect_rsp(2, 8, 1'b0);
    issue(2, 32'd6);
    drain(100);

`ifdef COLLATZ_SCHED_TIMEOUT_EN
    $display("[TB] txn: req0 n=0 timeout");
    expect_rsp(0, MAX_ITER, 1'b1);
    issue(0, 32'd0);
    drain(MAX_ITER + 100);
    $display("[TB] txn: req1 n=6 after timeout");
    expect_rsp(1, 8, 1'b0);
    issue(1, 32'd6);
    drain(100);
`endif

    check("gnt_queue_empty", 64'(exp_gnt.size()), 64'd0);
    check("cn_queue_empty", 64'(exp_cn.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
